// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its buffer.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] FETCH_BUBBLE = 32'h0;
  localparam logic [XLEN-1:0] PC_STEP      = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Sequential PC advance; wraps modulo 2^XLEN with no alignment checks.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; flush wins over a same-cycle push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int FIFO_DEPTH = 2,
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  fetch_entry_t     r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;
  logic             w_do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (r_count == '0);
  assign full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign count    = r_count;
  assign pop_data = r_mem[r_rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_pop  = pop && !empty && !flush;
  assign w_do_push = push && !flush && (!full || w_do_pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC generation, credit-limited imem issue, response buffering,
// and the fd_pc/fd_instr registers feeding decode (stall, redirect, squash).
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
  parameter int              FIFO_DEPTH      = 2,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            branch_en,
  input  logic [XLEN-1:0] branch_PC,
  output logic [XLEN-1:0] fd_pc,
  output logic [XLEN-1:0] fd_instr
);

  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + FIFO_DEPTH + 1) + 1;

  logic [XLEN-1:0]   r_pc_q;
  logic [XLEN-1:0]   r_resp_pc;
  logic [CNT_W-1:0]  r_out_cnt;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic [XLEN-1:0]   r_fd_pc_p1;
  logic [XLEN-1:0]   r_fd_instr_p1;

  logic              w_redirect;
  logic              w_pop;
  logic              w_issue;
  logic              w_push;
  logic              w_drop_rsp;
  logic              w_credit_ok;
  logic [CNT_W-1:0]  w_used;
  logic [FCNT_W-1:0] w_fifo_count;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  fetch_entry_t      w_fifo_head;
  fetch_entry_t      w_push_entry;

  // Stall has priority: a branch under stall is ignored and re-presented by decode.
  assign w_redirect = branch_en && !stall;
  assign w_pop      = !stall && !branch_en && !w_fifo_empty;

  // Credit: live in-flight requests plus buffered entries must fit the FIFO
  // after this cycle's pop, so a response never finds the buffer full.
  assign w_used      = (r_out_cnt - r_drop_cnt) + CNT_W'(w_fifo_count);
  assign w_credit_ok = w_used < (CNT_W'(FIFO_DEPTH) + CNT_W'(w_pop));

  assign imem_req  = reset && !w_redirect
                  && (r_out_cnt < CNT_W'(MAX_OUTSTANDING)) && w_credit_ok;
  assign imem_addr = r_pc_q;
  assign w_issue   = imem_req && imem_gnt;

  assign w_drop_rsp   = imem_rvalid && (r_drop_cnt != '0);
  assign w_push       = imem_rvalid && (r_drop_cnt == '0);
  assign w_push_entry = '{pc: r_resp_pc, instr: imem_rdata};

  fetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .flush     (w_redirect),
    .pop_data  (w_fifo_head),
    .count     (w_fifo_count),
    .empty     (w_fifo_empty),
    .full      (w_fifo_full)
  );

  // Issue / response bookkeeping
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc_q     <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_out_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_out_cnt <= r_out_cnt + CNT_W'(w_issue) - CNT_W'(imem_rvalid);
      if (w_redirect) begin
        r_pc_q     <= branch_PC;
        r_resp_pc  <= branch_PC;
        r_drop_cnt <= r_out_cnt - CNT_W'(imem_rvalid);
      end else begin
        if (w_issue)    r_pc_q     <= pc_inc(r_pc_q);
        if (w_push)     r_resp_pc  <= pc_inc(r_resp_pc);
        if (w_drop_rsp) r_drop_cnt <= r_drop_cnt - 1'b1;
      end
    end
  end

  // Stage boundary: fetch -> decode registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fd_pc_p1    <= FETCH_BUBBLE;
      r_fd_instr_p1 <= FETCH_BUBBLE;
    end else if (w_redirect) begin
      r_fd_pc_p1    <= FETCH_BUBBLE;
      r_fd_instr_p1 <= FETCH_BUBBLE;
    end else if (!stall) begin
      if (w_pop) begin
        r_fd_pc_p1    <= w_fifo_head.pc;
        r_fd_instr_p1 <= w_fifo_head.instr;
      end else begin
        r_fd_pc_p1    <= FETCH_BUBBLE;
        r_fd_instr_p1 <= FETCH_BUBBLE;
      end
    end
  end

  assign fd_pc    = r_fd_pc_p1;
  assign fd_instr = r_fd_instr_p1;

  a_rvalid_has_outstanding: assert property (
    @(posedge clock) disable iff (!reset) !(imem_rvalid && (r_out_cnt == '0)));

  a_fifo_no_overflow: assert property (
    @(posedge clock) disable iff (!reset)
    !(w_push && !w_redirect && w_fifo_full && !w_pop));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: in-order latency-configurable imem model,
// a stream-level reference for the decode side, and literal per-cycle pins.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          MAX_OUT  = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        branch_en = 1'b0;
  logic [31:0] branch_PC = 32'h0;
  logic [31:0] fd_pc;
  logic [31:0] fd_instr;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  fetch_stage #(
    .RESET_PC        (RESET_PC),
    .FIFO_DEPTH      (2),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .branch_en   (branch_en),
    .branch_PC   (branch_PC),
    .fd_pc       (fd_pc),
    .fd_instr    (fd_instr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  // Instruction memory: word at address A holds ~A; responses in order after lat cycles.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          lat = 1;
  int          mcyc = 0;
  logic        hs_fire = 1'b0;
  logic [31:0] hs_addr = 32'h0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mq.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      mcyc        = 0;
    end else begin
      #1;
      mcyc++;
      if (imem_rvalid) void'(mq.pop_front());
      if (hs_fire) begin
        mreq_t e;
        e.addr = hs_addr;
        e.due  = mcyc - 1 + lat;
        mq.push_back(e);
      end
      if (mq.size() > 0 && mq[0].due <= mcyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = ~mq[0].addr;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end
    end
  end

  // Stream reference: decode must see consecutive PCs from RESET_PC or the last
  // accepted redirect, bubbles in between, held values under stall.
  logic [31:0] m_next_pc, m_issue_pc, m_prev_pc, m_prev_instr, m_prev_addr, m_prev_bpc;
  logic        m_prev_stall, m_prev_redir, m_prev_req, m_prev_gnt;

  always @(negedge clock) begin
    if (!reset) begin
      chk("rst_fd_pc", fd_pc, 32'h0);
      chk("rst_fd_instr", fd_instr, 32'h0);
      chk("rst_req", 32'(imem_req), 32'h0);
      m_next_pc    = RESET_PC;
      m_issue_pc   = RESET_PC;
      m_prev_pc    = 32'h0;
      m_prev_instr = 32'h0;
      m_prev_addr  = 32'h0;
      m_prev_bpc   = 32'h0;
      m_prev_stall = 1'b0;
      m_prev_redir = 1'b0;
      m_prev_req   = 1'b0;
      m_prev_gnt   = 1'b0;
      hs_fire      = 1'b0;
    end else begin
      if (m_prev_stall) begin
        chk("stall_hold_pc", fd_pc, m_prev_pc);
        chk("stall_hold_instr", fd_instr, m_prev_instr);
      end else if (m_prev_redir) begin
        chk("redir_fd_pc", fd_pc, 32'h0);
        chk("redir_fd_instr", fd_instr, 32'h0);
        m_next_pc = m_prev_bpc;
      end else if (fd_instr == FETCH_BUBBLE) begin
        chk("bubble_pc", fd_pc, 32'h0);
      end else begin
        chk("seq_pc", fd_pc, m_next_pc);
        chk("seq_instr", fd_instr, ~m_next_pc);
        m_next_pc = m_next_pc + 32'd4;
      end

      if (imem_req && imem_gnt) begin
        chk("issue_addr", imem_addr, m_issue_pc);
        m_issue_pc = m_issue_pc + 32'd4;
      end
      if (branch_en && !stall) begin
        chk("redir_req", 32'(imem_req), 32'h0);
        m_issue_pc = branch_PC;
      end
      if (m_prev_req && !m_prev_gnt && !(branch_en && !stall) && stall == m_prev_stall) begin
        chk("gnt_wait_req", 32'(imem_req), 32'h1);
        chk("gnt_wait_addr", imem_addr, m_prev_addr);
      end
      chk("outstanding_bound",
          ((mq.size() + int'(imem_req && imem_gnt) - int'(imem_rvalid)) <= MAX_OUT) ? 32'h1 : 32'h0,
          32'h1);

      m_prev_stall = stall;
      m_prev_redir = branch_en && !stall;
      m_prev_bpc   = branch_PC;
      m_prev_pc    = fd_pc;
      m_prev_instr = fd_instr;
      m_prev_req   = imem_req;
      m_prev_gnt   = imem_gnt;
      m_prev_addr  = imem_addr;
      hs_fire      = imem_req && imem_gnt;
      hs_addr      = imem_addr;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  initial begin
    repeat (3) cyc();
    reset = 1'b1;
    smp();
    chk("t1_req_c0", 32'(imem_req), 32'h1);
    chk("t1_addr_c0", imem_addr, RESET_PC);

    // Zero-wait streaming, stall at fd_pc=8, stall+branch at fd_pc=0x10, gnt hold-off.
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (k == 5)  stall = 1'b1;
      if (k == 8)  stall = 1'b0;
      if (k == 10) begin stall = 1'b1; branch_en = 1'b1; branch_PC = 32'h80; end
      if (k == 11) begin stall = 1'b0; branch_en = 1'b0; end
      if (k == 12) imem_gnt = 1'b0;
      if (k == 16) imem_gnt = 1'b1;
      smp();
      case (k)
        1:  chk("t1_addr_c1", imem_addr, 32'h4);
        2:  begin chk("t1_addr_c2", imem_addr, 32'h8); chk("t1_bubble_c2", fd_instr, 32'h0); end
        3:  begin chk("t1_addr_c3", imem_addr, 32'hC);
                  chk("t1_fdpc_c3", fd_pc, 32'h0); chk("t1_fdin_c3", fd_instr, 32'hFFFF_FFFF); end
        4:  begin chk("t1_addr_c4", imem_addr, 32'h10);
                  chk("t1_fdpc_c4", fd_pc, 32'h4); chk("t1_fdin_c4", fd_instr, 32'hFFFF_FFFB); end
        5:  begin chk("t2_fdpc_c5", fd_pc, 32'h8); chk("t2_req_c5", 32'(imem_req), 32'h0);
                  chk("t2_addr_c5", imem_addr, 32'h14); end
        6:  begin chk("t2_fdpc_c6", fd_pc, 32'h8); chk("t2_req_c6", 32'(imem_req), 32'h0); end
        7:  begin chk("t2_fdpc_c7", fd_pc, 32'h8); chk("t2_fdin_c7", fd_instr, 32'hFFFF_FFF7);
                  chk("t2_req_c7", 32'(imem_req), 32'h0); end
        8:  begin chk("t2_fdpc_c8", fd_pc, 32'h8); chk("t2_req_c8", 32'(imem_req), 32'h1);
                  chk("t2_addr_c8", imem_addr, 32'h14); end
        9:  chk("t2_fdpc_c9", fd_pc, 32'hC);
        10: begin chk("t2_fdpc_c10", fd_pc, 32'h10); chk("t4_req_c10", 32'(imem_req), 32'h0); end
        11: begin chk("t4_fdpc_hold", fd_pc, 32'h10); chk("t4_pcq_kept", imem_addr, 32'h1C);
                  chk("t4_req_c11", 32'(imem_req), 32'h1); end
        12: begin chk("t4_no_drop_pc", fd_pc, 32'h14);
                  chk("t5_req_c12", 32'(imem_req), 32'h1); chk("t5_addr_c12", imem_addr, 32'h20); end
        13: begin chk("t5_fdpc_c13", fd_pc, 32'h18); chk("t5_addr_c13", imem_addr, 32'h20); end
        14: begin chk("t5_fdpc_c14", fd_pc, 32'h1C); chk("t5_req_c14", 32'(imem_req), 32'h1); end
        15: begin chk("t5_bubble_c15", fd_instr, 32'h0); chk("t5_addr_c15", imem_addr, 32'h20); end
        16: begin chk("t5_bubble_c16", fd_instr, 32'h0); chk("t5_addr_c16", imem_addr, 32'h20); end
        17: begin chk("t5_bubble_c17", fd_instr, 32'h0); chk("t5_addr_c17", imem_addr, 32'h24); end
        18: chk("t5_bubble_c18", fd_instr, 32'h0);
        19: begin chk("t5_fdpc_c19", fd_pc, 32'h20); chk("t5_fdin_c19", fd_instr, 32'hFFFF_FFDF); end
        20: chk("t5_fdpc_c20", fd_pc, 32'h24);
        default: ;
      endcase
    end

    // Asynchronous reset between clock edges.
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_fd_pc", fd_pc, 32'h0);
    chk("t6_async_fd_instr", fd_instr, 32'h0);
    chk("t6_async_req", 32'(imem_req), 32'h0);
    lat = 2;
    repeat (2) cyc();
    reset = 1'b1;
    smp();
    chk("t6_first_addr", imem_addr, RESET_PC);
    chk("t6_first_req", 32'(imem_req), 32'h1);

    // Two-cycle memory; redirect to 0x40 with two requests in flight.
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k == 2) begin branch_en = 1'b1; branch_PC = 32'h40; end
      if (k == 3) branch_en = 1'b0;
      smp();
      case (k)
        1: begin chk("t3_addr_c1", imem_addr, 32'h4); chk("t3_req_c1", 32'(imem_req), 32'h1); end
        2: begin chk("t3_req_c2", 32'(imem_req), 32'h0); chk("t3_inflight_c2", 32'(mq.size()), 32'h2);
                 chk("t3_rvalid_c2", 32'(imem_rvalid), 32'h1); end
        3: begin chk("t3_fdin_c3", fd_instr, 32'h0); chk("t3_fdpc_c3", fd_pc, 32'h0);
                 chk("t3_addr_c3", imem_addr, 32'h40); chk("t3_req_c3", 32'(imem_req), 32'h1); end
        4: begin chk("t3_fdin_c4", fd_instr, 32'h0); chk("t3_addr_c4", imem_addr, 32'h44); end
        5: chk("t3_fdin_c5", fd_instr, 32'h0);
        6: chk("t3_fdin_c6", fd_instr, 32'h0);
        7: begin chk("t3_fdpc_c7", fd_pc, 32'h40); chk("t3_fdin_c7", fd_instr, 32'hFFFF_FFBF); end
        8: chk("t3_fdpc_c8", fd_pc, 32'h44);
        default: ;
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Pipeline fetch stage; the producer end of the fetch→decode interface.
- Generates the PC and issues requests to a variable-latency instruction memory through a req/gnt + rvalid handshake.
- Buffers returned instructions in a small FIFO and drives the fd_pc/fd_instr pipeline registers.
- Obeys decode's stall (hold) and branch_en/branch_PC (redirect and squash).

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries (≥ memory latency + 1 for 1 instr/cycle).
- MAX_OUTSTANDING, 2, maximum in-flight imem requests, including ones marked for drop.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  request valid.
- imem_addr  out  32  request address (word aligned).
- imem_gnt  in  1  request accepted this cycle; ignored when imem_req=0.
- imem_rvalid  in  1  in-order response valid.
- imem_rdata  in  32  response instruction.
- stall  in  1  decode did not consume fd_* this cycle.
- branch_en  in  1  redirect request from decode.
- branch_PC  in  32  redirect target.
- fd_pc  out  32  PC of instruction presented to decode.
- fd_instr  out  32  instruction to decode; 32'h0 = bubble.

Behaviour:
- Reset (async, reset=0):
  - pc_q=RESET_PC, resp_pc=RESET_PC.
  - outstanding_cnt=0, drop_cnt=0, FIFO empty.
  - fd_pc=0, fd_instr=0, imem_req=0.
  - No imem response may arrive for pre-reset requests; imem is reset together with this block.
- Issue:
  - imem_addr=pc_q.
  - imem_req=1 iff all of:
    - !(branch_en && !stall);
    - outstanding_cnt < MAX_OUTSTANDING;
    - (outstanding_cnt − drop_cnt) + fifo_count − pop < FIFO_DEPTH, where pop is this cycle's FIFO pop.
  - On imem_req && imem_gnt: pc_q += 4, outstanding_cnt++.
  - While imem_gnt=0, imem_req and imem_addr stay stable.
- Response:
  - On imem_rvalid, outstanding_cnt-- (net with a same-cycle issue).
  - If drop_cnt>0: discard the response, drop_cnt--.
  - Else: push {resp_pc, imem_rdata} into the FIFO, resp_pc += 4.
  - The credit rule guarantees the FIFO never overflows.
  - imem_rvalid with outstanding_cnt=0 is a protocol error (assertion).
- Output advance, when stall=0 and branch_en=0:
  - FIFO non-empty: pop into fd_pc/fd_instr.
  - FIFO empty: fd_pc=0, fd_instr=0 (bubble).
  - Push and pop in the same cycle are both allowed.
- Stall=1:
  - fd_pc/fd_instr hold.
  - branch_en is ignored (stall has priority); decode re-evaluates next cycle.
  - Issue and response continue under the credit rule.
- Redirect, when branch_en=1 and stall=0, at that clock edge:
  - fd_pc=0, fd_instr=0.
  - FIFO flushed, including any same-cycle push.
  - pc_q=branch_PC, resp_pc=branch_PC.
  - drop_cnt = outstanding_cnt − imem_rvalid, i.e. all still-in-flight requests are dropped.
  - imem_req is forced 0 in this cycle.
  - First target request is issued next cycle.
- Latency and throughput:
  - Zero-wait memory (gnt same cycle, rvalid next cycle): first instr at fd_* 3 cycles after reset deassertion.
  - 1 instr/cycle sustained at default parameters.
- Arithmetic: PC increment is modulo 2^32; no alignment checks; branch_PC[1:0] is passed through as given.

Decomposition:
- Package fetch_pkg holds:
  - FETCH_BUBBLE = 32'h0;
  - PC_STEP = 4;
  - XLEN = 32;
  - the fetch entry typedef {pc[31:0], instr[31:0]}.
- Sub-module fetch_fifo:
  - synchronous FIFO of fetch entries, depth FIFO_DEPTH;
  - ports push, pop, flush, count, empty, full;
  - flush has priority over push.
- Counters and PC logic stay in fetch_stage.

Test Plan:
- Reset release, zero-wait memory, RESET_PC=0:
  - imem_addr 0,4,8,… on consecutive cycles;
  - fd_pc 0,4,8,12 on consecutive cycles from cycle 3, no bubbles.
- stall=1 for 3 cycles while fd_pc=8:
  - fd_pc/fd_instr hold 8;
  - imem issues stop once FIFO_DEPTH entries are buffered;
  - after release fd_pc 12,16,20 with no gap.
- 2-cycle memory latency, branch_en=1, branch_PC=0x40 with 2 requests outstanding:
  - next cycle fd_instr=0;
  - both stale responses are discarded;
  - next non-bubble fd_pc=0x40, then 0x44.
- stall=1 and branch_en=1 in the same cycle with fd_pc=0x10:
  - fd_pc stays 0x10;
  - pc_q unchanged;
  - no drop recorded.
- imem_gnt held 0 for 4 cycles with pc_q=0x20:
  - imem_req=1 and imem_addr=0x20 stable;
  - fd_instr=0 bubbles once the FIFO drains;
  - fetch resumes at 0x20.
- reset driven low mid-stream (asynchronously, between edges):
  - fd_pc=0, fd_instr=0, imem_req=0 immediately;
  - after release the first imem_addr is RESET_PC.
